generation_scheduler: RTL

GENERATION_SCHEDULER -- requirements
Module: generation_scheduler

---
 rtl/ga_pkg.sv | 9 +
 rtl/rank_select.sv | 18 +
 rtl/generation_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared sizing constants and controller state encoding for the GA datapath
package ga_pkg;
    localparam int POP_SIZE = 50;
    localparam int ELITE    = 10;
    localparam int IDX_W    = 6;
    localparam int DIST_W   = 12;
    localparam int GEN_W    = 10;
    typedef enum logic [2:0] {S_IDLE, S_EVAL, S_SORT, S_BREED, S_DONE} state_e;
endpackage

// File: rtl/rank_select.sv
// rank_select: picks one IDX_W-wide index field out of a packed rank vector
module rank_select #(
    parameter int N     = ga_pkg::POP_SIZE,
    parameter int W     = ga_pkg::IDX_W,
    parameter int SEL_W = ga_pkg::IDX_W
) (
    input  logic [N*W-1:0]   vec_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [W-1:0]     idx_o
);
    import ga_pkg::*;
    // constant-offset mux keeps index arithmetic out of the select path
    always_comb begin
        idx_o = '0;
        for (int r = 0; r < N; r++)
            if (sel_i == SEL_W'(r)) idx_o = vec_i[r*W +: W];
    end
endmodule

// File: rtl/generation_scheduler.sv
// generation_scheduler: sequences evaluate -> sort -> breed per generation of the GA
module generation_scheduler #(
    parameter int POP_SIZE = ga_pkg::POP_SIZE,
    parameter int ELITE    = ga_pkg::ELITE,
    parameter int IDX_W    = ga_pkg::IDX_W,
    parameter int GEN_W    = ga_pkg::GEN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [GEN_W-1:0]          max_gen,
    output logic                      eval_start,
    input  logic                      eval_done,
    output logic                      sort_start,
    input  logic                      sort_done,
    input  logic [POP_SIZE*IDX_W-1:0] sorted,
    output logic                      breed_valid,
    input  logic                      breed_ready,
    output logic [IDX_W-1:0]          parent_a,
    output logic [IDX_W-1:0]          parent_b,
    output logic [IDX_W-1:0]          child_idx,
    output logic [GEN_W-1:0]          gen_count,
    output logic [IDX_W-1:0]          best_index,
    output logic                      busy,
    output logic                      done
);
    import ga_pkg::*;

    localparam int EW     = $clog2(ELITE);
    localparam int LAST_K = POP_SIZE - ELITE - 1;

    state_e                    state_q;
    logic [GEN_W-1:0]          gen_q, max_q, gen_inc;
    logic [POP_SIZE*IDX_W-1:0] rank_q;
    logic [IDX_W-1:0]          best_q, k_q;
    logic [IDX_W-1:0]          rank_a, rank_b, rank_c;
    logic [EW-1:0]             a_q, b_q, off_q;
    logic                      eval_start_q, sort_start_q;

    // a and b walk the elite ranks as mod-ELITE counters, so no divider is needed
    function automatic logic [EW-1:0] wrap(input logic [EW-1:0] x);
        return (x == EW'(ELITE-1)) ? '0 : x + 1'b1;
    endfunction

    assign gen_inc = &gen_q ? gen_q : gen_q + 1'b1;

    rank_select #(.N(POP_SIZE), .W(IDX_W), .SEL_W(IDX_W)) u_sel_a (
        .vec_i(rank_q), .sel_i(IDX_W'(a_q)), .idx_o(rank_a)
    );
    rank_select #(.N(POP_SIZE), .W(IDX_W), .SEL_W(IDX_W)) u_sel_b (
        .vec_i(rank_q), .sel_i(IDX_W'(b_q)), .idx_o(rank_b)
    );
    rank_select #(.N(POP_SIZE), .W(IDX_W), .SEL_W(IDX_W)) u_sel_c (
        .vec_i(rank_q), .sel_i(IDX_W'(ELITE) + k_q), .idx_o(rank_c)
    );

    // controller: one state register plus the pulses and counters it owns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gen_q        <= '0;
            max_q        <= '0;
            rank_q       <= '0;
            best_q       <= '0;
            k_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            off_q        <= '0;
            eval_start_q <= 1'b0;
            sort_start_q <= 1'b0;
        end else begin
            eval_start_q <= 1'b0;
            sort_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (max_gen == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            gen_q        <= '0;
                            max_q        <= max_gen;
                            off_q        <= EW'(1);
                            eval_start_q <= 1'b1;
                            state_q      <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    if (!eval_start_q && eval_done) begin
                        sort_start_q <= 1'b1;
                        state_q      <= S_SORT;
                    end
                end
                S_SORT: begin
                    // a done level left over from the previous sort is ignored on the start cycle
                    if (!sort_start_q && sort_done) begin
                        rank_q  <= sorted;
                        best_q  <= sorted[IDX_W-1:0];
                        k_q     <= '0;
                        a_q     <= '0;
                        b_q     <= off_q;
                        state_q <= S_BREED;
                    end
                end
                S_BREED: begin
                    if (breed_ready) begin
                        k_q <= k_q + 1'b1;
                        a_q <= wrap(a_q);
                        b_q <= wrap(b_q);
                        if (k_q == IDX_W'(LAST_K)) begin
                            gen_q <= gen_inc;
                            if (gen_inc != gen_q)
                                off_q <= (off_q == EW'(ELITE-1)) ? EW'(1) : off_q + 1'b1;
                            if (gen_inc == max_q) begin
                                state_q <= S_DONE;
                            end else begin
                                eval_start_q <= 1'b1;
                                state_q      <= S_EVAL;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign eval_start  = eval_start_q;
    assign sort_start  = sort_start_q;
    assign breed_valid = (state_q == S_BREED);
    assign busy        = (state_q == S_EVAL) || (state_q == S_SORT) || (state_q == S_BREED);
    assign done        = (state_q == S_DONE);
    assign gen_count   = gen_q;
    assign best_index  = best_q;
    assign parent_a    = breed_valid ? rank_a : '0;
    assign parent_b    = breed_valid ? rank_b : '0;
    assign child_idx   = breed_valid ? rank_c : '0;
endmodule
